set_host: RTL and testbench

- Initiator for the SET point-in-circle counter.
- Accepts jobs (central, radius, mode, tag) from an upstream valid/ready port and buffers them in a small FIFO.
- Launches one job at a time over SET's en/central/radius/mode interface and captures the one-cycle candidate pulse on valid.
- Returns the tagged result on a downstream valid/ready port. Sits between the system job source and the SET instance.

---
 rtl/set_pkg.sv | 32 +++
 rtl/set_host_fifo.sv | 44 ++++
 rtl/set_host.sv | 149 ++++++++++++++
 tb/tb_set_host.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/set_pkg.sv
// set_pkg: shared types and constants for the SET host (mode encodings, FSM states, field layout).
package set_pkg;

    localparam int GRID       = 8;
    localparam int PROC_CYC_A = 64;
    localparam int PROC_CYC_2 = 128;
    localparam int PROC_CYC_3 = 192;

    localparam int XA_OFF = 20;
    localparam int YA_OFF = 16;
    localparam int XB_OFF = 12;
    localparam int YB_OFF = 8;
    localparam int XC_OFF = 4;
    localparam int YC_OFF = 0;
    localparam int RA_OFF = 8;
    localparam int RB_OFF = 4;
    localparam int RC_OFF = 0;

    typedef enum logic [1:0] {MODE_A, MODE_AND, MODE_XOR, MODE_ODD} mode_e;
    typedef enum logic [1:0] {INIT, IDLE, LAUNCH, WAIT} state_e;

    typedef struct packed {
        logic [23:0] central;
        logic [11:0] radius;
        mode_e       mode;
    } job_t;

    function automatic int proc_cyc(input mode_e m);
        return (m == MODE_A) ? PROC_CYC_A : (m == MODE_ODD) ? PROC_CYC_3 : PROC_CYC_2;
    endfunction

endpackage

// File: rtl/set_host_fifo.sv
// set_host_fifo: synchronous job FIFO; a push on a full FIFO is taken only when a pop frees a slot that cycle.
module set_host_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 42
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] din_i,
    output logic [W-1:0] dout_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   cnt_q;
    logic          do_push, do_pop;

    assign full_o  = cnt_q == (AW+1)'(DEPTH);
    assign empty_o = cnt_q == '0;
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign dout_o  = mem_q[rd_q];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + AW'(1);
            if (do_pop) rd_q <= rd_q + AW'(1);
            cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din_i;
    end

endmodule

// File: rtl/set_host.sv
// set_host: queues jobs and runs them one at a time on SET, returning tagged results.
// Define SET_HOST_TIMEOUT_EN to bound WAIT by TIMEOUT cycles and report res_err.
module set_host
    import set_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
`ifdef SET_HOST_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 256
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             job_valid,
    output logic             job_ready,
    input  logic [23:0]      job_central,
    input  logic [11:0]      job_radius,
    input  logic [1:0]       job_mode,
    input  logic [TAG_W-1:0] job_tag,
    output logic             set_en,
    output logic [23:0]      set_central,
    output logic [11:0]      set_radius,
    output logic [1:0]       set_mode,
    input  logic             set_valid,
    input  logic [7:0]       set_candidate,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [7:0]       res_candidate,
    output logic [TAG_W-1:0] res_tag,
    output logic             res_err
);
    localparam int FW = $bits(job_t) + TAG_W;

    job_t             job_in, job_out;
    logic [TAG_W-1:0] tag_out;
    logic [FW-1:0]    fifo_dout;
    logic             fifo_full, fifo_empty, fifo_pop;

    state_e           state_q;
    logic             init_q;
    logic             set_en_q;
    logic [23:0]      set_central_q;
    logic [11:0]      set_radius_q;
    mode_e            set_mode_q;
    logic [TAG_W-1:0] tag_q;
    logic             res_valid_q;
    logic [7:0]       res_cand_q;
    logic [TAG_W-1:0] res_tag_q;
`ifdef SET_HOST_TIMEOUT_EN
    localparam logic [8:0] TO_LAST = 9'(TIMEOUT - 1);
    logic [8:0] wcnt_q;
    logic       res_err_q;
    assign res_err = res_err_q;
`else
    assign res_err = 1'b0;
`endif

    assign job_in    = '{central: job_central, radius: job_radius, mode: mode_e'(job_mode)};
    assign {job_out, tag_out} = fifo_dout;
    assign job_ready = !fifo_full;
    // Holding off while a result is unread guarantees a capture never overwrites it.
    assign fifo_pop  = (state_q == IDLE) && !fifo_empty && !res_valid_q;

    set_host_fifo #(.DEPTH(DEPTH), .W(FW)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (job_valid && !fifo_full),
        .pop_i   (fifo_pop),
        .din_i   ({job_in, job_tag}),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= INIT;
            init_q        <= 1'b0;
            set_en_q      <= 1'b1;
            set_central_q <= '0;
            set_radius_q  <= '0;
            set_mode_q    <= MODE_A;
            tag_q         <= '0;
            res_valid_q   <= 1'b0;
            res_cand_q    <= '0;
            res_tag_q     <= '0;
`ifdef SET_HOST_TIMEOUT_EN
            wcnt_q        <= '0;
            res_err_q     <= 1'b0;
`endif
        end else begin
            if (res_valid_q && res_ready) res_valid_q <= 1'b0;
            case (state_q)
                INIT: begin
                    init_q <= 1'b1;
                    if (init_q) state_q <= IDLE;
                end
                IDLE: if (fifo_pop) begin
                    set_central_q <= job_out.central;
                    set_radius_q  <= job_out.radius;
                    set_mode_q    <= job_out.mode;
                    tag_q         <= tag_out;
                    set_en_q      <= 1'b0;
                    state_q       <= LAUNCH;
`ifdef SET_HOST_TIMEOUT_EN
                    wcnt_q        <= '0;
`endif
                end
                LAUNCH: begin
                    set_en_q <= 1'b1;
                    state_q  <= WAIT;
`ifdef SET_HOST_TIMEOUT_EN
                    wcnt_q   <= wcnt_q + 9'd1;
`endif
                end
                WAIT: begin
                    if (set_valid) begin
                        res_valid_q <= 1'b1;
                        res_cand_q  <= set_candidate;
                        res_tag_q   <= tag_q;
                        state_q     <= IDLE;
`ifdef SET_HOST_TIMEOUT_EN
                        res_err_q   <= 1'b0;
                    end else if (wcnt_q == TO_LAST) begin
                        res_valid_q <= 1'b1;
                        res_cand_q  <= '0;
                        res_tag_q   <= tag_q;
                        res_err_q   <= 1'b1;
                        state_q     <= IDLE;
                    end else begin
                        wcnt_q <= wcnt_q + 9'd1;
`endif
                    end
                end
                default: state_q <= INIT;
            endcase
        end
    end

    assign set_en        = set_en_q;
    assign set_central   = set_central_q;
    assign set_radius    = set_radius_q;
    assign set_mode      = set_mode_q;
    assign res_valid     = res_valid_q;
    assign res_candidate = res_cand_q;
    assign res_tag       = res_tag_q;

endmodule

// File: tb/tb_set_host.sv
// tb_set_host: directed + random jobs against a behavioural SET stub and a point-counting scoreboard.
module tb_set_host;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        job_valid, job_ready;
    logic [23:0] job_central;
    logic [11:0] job_radius;
    logic [1:0]  job_mode;
    logic [3:0]  job_tag;
    logic        set_en;
    logic [23:0] set_central;
    logic [11:0] set_radius;
    logic [1:0]  set_mode;
    logic        set_valid = 1'b0;
    logic [7:0]  set_candidate = 8'h00;
    logic        res_valid, res_ready, res_err;
    logic [7:0]  res_candidate;
    logic [3:0]  res_tag;

    set_host dut (
        .clk(clk), .rst(rst), .job_valid(job_valid), .job_ready(job_ready),
        .job_central(job_central), .job_radius(job_radius), .job_mode(job_mode), .job_tag(job_tag),
        .set_en(set_en), .set_central(set_central), .set_radius(set_radius), .set_mode(set_mode),
        .set_valid(set_valid), .set_candidate(set_candidate),
        .res_valid(res_valid), .res_ready(res_ready), .res_candidate(res_candidate),
        .res_tag(res_tag), .res_err(res_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [23:0] c;
        logic [11:0] r;
        logic [1:0]  m;
        logic [3:0]  tag;
        int          cand;
    } job_s;

    job_s        exp_q[$];
    logic [37:0] lq[$];
    int n_tests = 0, n_fail = 0;
    int stub_mute = 0, inject_cnt = 0;
    int inject_done = 0, launches = 0, unstable = 0, rem = 0;
    logic        run = 1'b0;
    logic [37:0] run_f = '0;

    function automatic int inside_c(int px, int py, logic [3:0] cx, logic [3:0] cy, logic [3:0] r);
        int dx = px - int'(cx);
        int dy = py - int'(cy);
        return (dx * dx + dy * dy <= int'(r) * int'(r)) ? 1 : 0;
    endfunction

    // Count grid points satisfying the mode's region rule over circles A, B, C.
    function automatic int count_pts(logic [23:0] c, logic [11:0] r, logic [1:0] m);
        int n = 0;
        for (int x = 0; x < 8; x++)
            for (int y = 0; y < 8; y++) begin
                int a = inside_c(x, y, c[23:20], c[19:16], r[11:8]);
                int b = inside_c(x, y, c[15:12], c[11:8], r[7:4]);
                int k = inside_c(x, y, c[7:4], c[3:0], r[3:0]);
                int hit = (m == 2'd0) ? a : (m == 2'd1) ? (a & b) : (m == 2'd2) ? (a ^ b) : ((a + b + k) % 2);
                n += hit;
            end
        return n;
    endfunction

    function automatic int proc_len(logic [1:0] m);
        return (m == 2'd0) ? 64 : (m == 2'd3) ? 192 : 128;
    endfunction

    // SET stub: a launch is a cycle with en low; the result pulse comes N+1 cycles later.
    always @(negedge clk) begin
        if (!rst) begin
            run = 1'b0;
            set_valid = 1'b0;
        end else if (set_en === 1'b0) begin
            launches++;
            run = 1'b1;
            run_f = {set_central, set_radius, set_mode};
            rem = proc_len(set_mode) + 1;
            lq.push_back(run_f);
            set_valid = 1'b0;
        end else begin
            set_valid = 1'b0;
            if (run) begin
                if ({set_central, set_radius, set_mode} !== run_f) unstable++;
                rem--;
                if (rem == 0) begin
                    run = 1'b0;
                    if (stub_mute == 0) begin
                        set_valid = 1'b1;
                        set_candidate = 8'(count_pts(run_f[37:14], run_f[13:2], run_f[1:0]));
                    end
                end
            end
            if (inject_cnt != inject_done) begin
                inject_done++;
                set_valid = 1'b1;
                set_candidate = 8'h5A;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string t, input logic [63:0] o, input logic [63:0] e);
        n_tests++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", t, o, e);
        end
    endtask

    task automatic set_job(input logic [23:0] c, input logic [11:0] r, input logic [1:0] m, input logic [3:0] tg);
        job_central = c;
        job_radius  = r;
        job_mode    = m;
        job_tag     = tg;
        job_valid   = 1'b1;
    endtask

    task automatic note_job;
        job_s j;
        j.c = job_central; j.r = job_radius; j.m = job_mode; j.tag = job_tag;
        j.cand = count_pts(job_central, job_radius, job_mode);
        exp_q.push_back(j);
    endtask

    task automatic push_job(input logic [23:0] c, input logic [11:0] r, input logic [1:0] m, input logic [3:0] tg);
        bit ok = 0;
        set_job(c, r, m, tg);
        for (int i = 0; i < 2000 && !ok; i++) begin
            if (job_ready === 1'b1) ok = 1;
            tick;
        end
        job_valid = 1'b0;
        chk("push_accepted", 64'(ok), 64'd1);
        if (ok) note_job;
    endtask

    task automatic push_rand(input logic [3:0] tg);
        push_job(24'($urandom), 12'($urandom), 2'($urandom_range(0, 3)), tg);
    endtask

    task automatic wait_launch(output int lc);
        for (int i = 0; i < 1000 && set_en !== 1'b0; i++) tick;
        chk("launch_seen", 64'(set_en), 64'd0);
        lc = cyc;
    endtask

    task automatic wait_res(output int rc);
        for (int i = 0; i < 1000 && res_valid !== 1'b1; i++) tick;
        chk("res_arrive", 64'(res_valid), 64'd1);
        rc = cyc;
    endtask

    task automatic accept(output int ac);
        res_ready = 1'b1;
        tick;
        res_ready = 1'b0;
        ac = cyc;
        chk("res_clear", 64'(res_valid), 64'd0);
    endtask

    task automatic pop_exp(output job_s e);
        logic [37:0] lv = '1;
        e.c = '0; e.r = '0; e.m = '0; e.tag = '0; e.cand = -1;
        chk("exp_nonempty", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) e = exp_q.pop_front();
        if (lq.size() > 0) lv = lq.pop_front();
        chk("launch_fields", 64'(lv), 64'({e.c, e.r, e.m}));
    endtask

    task automatic get_res(input int hold, output int rc, output int ac);
        job_s e;
        bit stable = 1;
        int l0;
        logic [12:0] snap;
        wait_res(rc);
        pop_exp(e);
        chk("res_candidate", 64'(res_candidate), 64'(e.cand));
        chk("res_tag", 64'(res_tag), 64'(e.tag));
        chk("res_err", 64'(res_err), 64'd0);
        snap = {res_valid, res_candidate, res_tag};
        l0 = launches;
        for (int i = 0; i < hold; i++) begin
            tick;
            if ({res_valid, res_candidate, res_tag} !== snap || set_en !== 1'b1 || launches != l0) stable = 0;
        end
        if (hold > 0) chk("hold_stable", 64'(stable), 64'd1);
        accept(ac);
    endtask

    initial begin
        int l1, rc, ac, rel, l0;
        job_s e;
        bit quiet;
        job_valid = 1'b0; res_ready = 1'b0;
        job_central = '0; job_radius = '0; job_mode = '0; job_tag = '0;
        repeat (3) tick;
        chk("rst_set_en", 64'(set_en), 64'd1);
        chk("rst_set_central", 64'(set_central), 64'd0);
        chk("rst_set_radius", 64'(set_radius), 64'd0);
        chk("rst_set_mode", 64'(set_mode), 64'd0);
        chk("rst_res_valid", 64'(res_valid), 64'd0);
        chk("rst_res_candidate", 64'(res_candidate), 64'd0);
        chk("rst_res_tag", 64'(res_tag), 64'd0);
        chk("rst_res_err", 64'(res_err), 64'd0);
        chk("rst_job_ready", 64'(job_ready), 64'd1);

        // Mode 0 single circle; INIT delay and exact launch-to-result latency.
        set_job(24'h440000, 12'h300, 2'd0, 4'd3);
        rel = cyc;
        rst = 1'b1;
        tick;
        job_valid = 1'b0;
        note_job;
        wait_launch(l1);
        chk("init_to_launch", 64'(l1 - rel), 64'd3);
        tick;
        chk("en_low_one_cycle", 64'(set_en), 64'd1);
        wait_res(rc);
        chk("latency_mode0", 64'(rc - l1), 64'd66);
        chk("mode0_count29", 64'(res_candidate), 64'd29);
        get_res(0, rc, ac);

        // Modes 1 and 2 on coincident circles; second waits for the first accept.
        push_job(24'h444400, 12'h330, 2'd1, 4'd5);
        push_job(24'h444400, 12'h330, 2'd2, 4'd6);
        wait_res(rc);
        chk("mode1_count29", 64'(res_candidate), 64'd29);
        get_res(0, rc, ac);
        wait_launch(l1);
        chk("relaunch_after_accept", 64'(l1 - ac), 64'd1);
        wait_res(rc);
        chk("mode2_count0", 64'(res_candidate), 64'd0);
        get_res(0, rc, ac);

        // Back-to-back: fill the FIFO behind one in-flight job, stall the result port.
        for (int i = 0; i < 5; i++) push_rand(4'(8 + i));
        chk("full_ready_low", 64'(job_ready), 64'd0);
        set_job(24'h123456, 12'h234, 2'd3, 4'd13);
        get_res(100, rc, ac);
        push_job(24'h123456, 12'h234, 2'd3, 4'd13);
        chk("refull_ready_low", 64'(job_ready), 64'd0);
        for (int i = 0; i < 5; i++) get_res($urandom_range(0, 3), rc, ac);
        chk("drained", 64'(exp_q.size()), 64'd0);

        // Stray set_valid with nothing in flight must be ignored.
        l0 = launches;
        inject_cnt++;
        repeat (3) tick;
        chk("stray_valid_ignored", 64'(res_valid), 64'd0);
        chk("stray_no_launch", 64'(launches), 64'(l0));

        // SET never answers.
        stub_mute = 1;
        push_job(24'h777777, 12'h222, 2'd1, 4'd2);
        wait_launch(l1);
`ifdef SET_HOST_TIMEOUT_EN
        wait_res(rc);
        chk("timeout_latency", 64'(rc - l1), 64'd256);
        chk("timeout_err", 64'(res_err), 64'd1);
        chk("timeout_cand", 64'(res_candidate), 64'd0);
        chk("timeout_tag", 64'(res_tag), 64'd2);
        pop_exp(e);
        inject_cnt++;
        repeat (3) tick;
        chk("late_valid_ignored", 64'({res_valid, res_err, res_candidate}), 64'({1'b1, 1'b1, 8'h00}));
        accept(ac);
`else
        quiet = 1;
        repeat (300) begin
            tick;
            if (res_valid !== 1'b0 || set_en !== 1'b1) quiet = 0;
        end
        chk("wait_unbounded", 64'(quiet), 64'd1);
        inject_cnt++;
        wait_res(rc);
        pop_exp(e);
        chk("late_cand", 64'(res_candidate), 64'h5A);
        chk("late_tag", 64'(res_tag), 64'd2);
        chk("late_err", 64'(res_err), 64'd0);
        accept(ac);
`endif
        stub_mute = 0;

        // Reset in the middle of WAIT drops everything queued.
        push_rand(4'd1);
        push_rand(4'd4);
        wait_launch(l1);
        repeat (10) tick;
        rst = 1'b0;
        #1;
        chk("midrst_set_en", 64'(set_en), 64'd1);
        chk("midrst_res_valid", 64'(res_valid), 64'd0);
        chk("midrst_job_ready", 64'(job_ready), 64'd1);
        tick;
        chk("midrst_set_en_next", 64'(set_en), 64'd1);
        exp_q.delete();
        lq.delete();
        set_job(24'h440000, 12'h300, 2'd0, 4'd9);
        rel = cyc;
        rst = 1'b1;
        tick;
        job_valid = 1'b0;
        note_job;
        wait_launch(l1);
        chk("reinit_to_launch", 64'(l1 - rel), 64'd3);
        get_res(0, rc, ac);
        l0 = launches;
        repeat (300) tick;
        chk("queued_jobs_lost", 64'(launches), 64'(l0));

        // Random jobs with a moving backlog.
        for (int i = 0; i < 8; i++) begin
            push_rand(4'($urandom));
            if (exp_q.size() >= 3 || i == 7) begin
                while (exp_q.size() > 0) get_res($urandom_range(0, 4), rc, ac);
            end
        end
        chk("fields_stable_in_wait", 64'(unstable), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
